// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- oversampling UART receiver with optional parity.
//
// Frames are a start bit (low), DWIDTH data bits LSB-first, an optional
// parity bit, and one stop bit (high). rx_in is synchronized before use.
// Each bit period is OVERSAMPLE clocks. The bit value is decided at
// edge_cnt == OVERSAMPLE/2+1.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   -> the decision bit is the majority of rxs at
//                edge_cnt OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1
//   undefined -> the decision bit is rxs sampled at edge_cnt OVERSAMPLE/2
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   rx_in        serial line, idle high, asynchronous to clk
//   par_en       frame carries a parity bit (latched at frame start)
//   par_typ      0 = even parity, 1 = odd parity (latched at frame start)
//   p_data       last good received word
//   data_valid   one-cycle pulse on a good frame
//   parity_error parity mismatch on current/last frame
//   stop_error   stop bit sampled low
//   busy         receiver is not idle
module uart_rx_ctrl #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_typ,
  output logic [DWIDTH-1:0] p_data,
  output logic              data_valid,
  output logic              parity_error,
  output logic              stop_error,
  output logic              busy
);

  localparam int unsigned EW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DWIDTH);

  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] EDGE_MID  = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] EDGE_DEC  = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              rxs_q, rxs_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [DWIDTH-1:0] p_data_q, p_data_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_error_q, parity_error_d;
  logic              stop_error_q, stop_error_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              samp_mid_q, samp_mid_d;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] EDGE_PRE = EW'(OVERSAMPLE / 2 - 1);
  logic              samp_pre_q, samp_pre_d;
`endif

  logic is_dec;
  logic is_wrap;
  logic dec_bit;
  logic exp_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b1;
      rxs_q          <= 1'b1;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      samp_mid_q     <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp_pre_q     <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      rxs_q          <= rxs_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      samp_mid_q     <= samp_mid_d;
`ifdef UART_RX_MAJORITY_EN
      samp_pre_q     <= samp_pre_d;
`endif
    end
  end

  always_comb begin
    sync1_d        = rx_in;
    rxs_d          = sync1_q;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;

    is_dec  = (edge_cnt_q == EDGE_DEC);
    is_wrap = (edge_cnt_q == EDGE_LAST);
    edge_cnt_d = is_wrap ? '0 : edge_cnt_q + EW'(1);

    // Earlier samples are held in flops so both decision modes resolve in
    // the same cycle (edge_cnt == OVERSAMPLE/2+1) with identical latency.
    samp_mid_d = (edge_cnt_q == EDGE_MID) ? rxs_q : samp_mid_q;
`ifdef UART_RX_MAJORITY_EN
    samp_pre_d = (edge_cnt_q == EDGE_PRE) ? rxs_q : samp_pre_q;
    dec_bit    = (samp_pre_q & samp_mid_q) | (samp_pre_q & rxs_q) |
                 (samp_mid_q & rxs_q);
`else
    dec_bit    = samp_mid_q;
`endif

    exp_par = par_typ_q ? ~^shift_q : ^shift_q;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rxs_q) begin
          state_d        = START;
          par_en_d       = par_en;
          par_typ_d      = par_typ;
          parity_error_d = 1'b0;
          stop_error_d   = 1'b0;
        end
      end
      START: begin
        if (is_dec && dec_bit) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (is_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (is_dec) begin
          shift_d = {dec_bit, shift_q[DWIDTH-1:1]};
        end
        if (is_wrap) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (is_dec) begin
          parity_error_d = (dec_bit != exp_par);
        end
        if (is_wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave half a bit early so the next start edge is never missed.
        if (is_dec) begin
          stop_error_d = ~dec_bit;
          state_d      = IDLE;
          edge_cnt_d   = '0;
          if (!parity_error_q && dec_bit) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  assign p_data       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl (DWIDTH=8, OVERSAMPLE=16). Frames are driven
// bit-serially; expected words go into a scoreboard queue when a frame is
// sent and are popped when data_valid pulses.
module tb_uart_rx_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;

  logic          clk;
  logic          rst;
  logic          rx_in;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;
  logic          busy;

  int unsigned vectors;
  int unsigned miscompares;

  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  logic       last_pe;
  logic       last_se;
  logic       dv_prev;

  uart_rx_ctrl #(
    .DWIDTH    (DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .stop_error  (stop_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        check("dv_one_cycle", {31'b0, dv_prev}, 32'd0);
        if (exp_q.size() == 0) check("unexpected_dv", {31'b0, data_valid}, 32'd0);
        else                   check("p_data", {24'b0, p_data}, {24'b0, exp_q.pop_front()});
      end
      dv_prev = data_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame. The stop bit is held stop_len cycles, then the line
  // idles high for tail cycles. gl_idx/gl_cyc invert one cycle of one bit.
  // abort_idx asserts reset 4 cycles into that bit and returns.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                            input bit pbit, input bit stopv, input int stop_len,
                            input int tail, input int gl_idx, input int gl_cyc,
                            input int abort_idx);
    logic bits [0:11];
    int   n;
    int   len;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (pen) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stopv;
    n++;
    par_en  = pen;
    par_typ = ptyp;
    for (int i = 0; i < n; i++) begin
      len = (i == n - 1) ? stop_len : OS;
      for (int c = 0; c < len; c++) begin
        if (i == abort_idx && c == 4) begin
          rst = 1'b0;
          return;
        end
        rx_in = (i == gl_idx && c == gl_cyc) ? ~bits[i] : bits[i];
        // Mode pins change mid-frame; the receiver must use the latched ones.
        if (i == 0 && c == 8) begin
          par_en  = ~pen;
          par_typ = ~ptyp;
        end
        tick(1);
      end
    end
    rx_in = 1'b1;
    tick(tail);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                           input bit pbit, input bit stopv, input int stop_len,
                           input int tail, input int gl_idx, input int gl_cyc,
                           input logic [7:0] exp_word);
    logic want_par;
    want_par = ptyp ? ~^d : ^d;
    last_pe  = pen && (pbit != want_par);
    last_se  = !stopv;
    if (!last_pe && !last_se) begin
      exp_q.push_back(exp_word);
      last_good = exp_word;
    end
    send_frame(d, pen, ptyp, pbit, stopv, stop_len, tail, gl_idx, gl_cyc, -1);
  endtask

  task automatic post_check(input string tag);
    tick(4);
    check({tag, "_sb_drain"}, exp_q.size(), 32'd0);
    check({tag, "_parity_error"}, {31'b0, parity_error}, {31'b0, last_pe});
    check({tag, "_stop_error"}, {31'b0, stop_error}, {31'b0, last_se});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_p_data"}, {24'b0, p_data}, {24'b0, last_good});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         pen;
    bit         ptyp;
    bit         busy_seen;
    logic [7:0] glitch_exp;

    vectors     = 0;
    miscompares = 0;
    last_good   = 8'h00;
    last_pe     = 1'b0;
    last_se     = 1'b0;
    dv_prev     = 1'b0;
    rst         = 1'b0;
    rx_in       = 1'b1;
    par_en      = 1'b0;
    par_typ     = 1'b0;

    tick(3);
    check("rst_p_data", {24'b0, p_data}, 32'd0);
    check("rst_dv", {31'b0, data_valid}, 32'd0);
    check("rst_pe", {31'b0, parity_error}, 32'd0);
    check("rst_se", {31'b0, stop_error}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    tick(4);

    // No parity, 0xA5.
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, OS, 4, -1, 0, 8'hA5);
    post_check("a5");

    // Even parity 0x3C: correct parity, then wrong parity.
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, OS, 4, -1, 0, 8'h3C);
    post_check("3c_ok");
    run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, OS, 4, -1, 0, 8'h3C);
    post_check("3c_perr");

    // Odd parity 0x01 good; 0x00 with a low stop bit. The low stop bit is
    // shortened so the line is high again when the receiver returns to IDLE.
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, OS, 4, -1, 0, 8'h01);
    post_check("01_odd");
    run_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 11, 8, -1, 0, 8'h00);
    post_check("00_serr");

    // Random well-formed frames.
    for (int k = 0; k < 4; k++) begin
      d    = 8'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      run_frame(d, pen, ptyp, ptyp ? ~^d : ^d, 1'b1, OS, 4, -1, 0, d);
      post_check("rand");
    end

    // Short low pulse: START then back to IDLE, no output change.
    busy_seen = 1'b0;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (busy) busy_seen = 1'b1;
    end
    check("fs_busy_seen", {31'b0, busy_seen}, 32'd1);
    last_pe = 1'b0;
    last_se = 1'b0;
    post_check("false_start");

    // Back to back: next start bit reaches IDLE in the data_valid cycle.
    run_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 11, 0, -1, 0, 8'h96);
    run_frame(8'h69, 1'b1, 1'b0, 1'b0, 1'b1, OS, 4, -1, 0, 8'h69);
    post_check("b2b");

    // Reset during data bit 3 of 0x5A.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, OS, 0, -1, 0, 4);
    #1;
    check("abort_p_data", {24'b0, p_data}, 32'd0);
    check("abort_dv", {31'b0, data_valid}, 32'd0);
    check("abort_pe", {31'b0, parity_error}, 32'd0);
    check("abort_se", {31'b0, stop_error}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    last_good = 8'h00;
    rx_in = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(4);
    check("abort_sb_empty", exp_q.size(), 32'd0);
    run_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, OS, 4, -1, 0, 8'hC3);
    post_check("c3");

    // One-cycle glitch on rxs at edge_cnt 8 of data bit 2 of 0xFF.
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFB;
`endif
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, OS, 4, 3, 9, glitch_exp);
    post_check("glitch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning clk cycles per bit period (even, 8..64).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port par_en  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port p_data  output  DWIDTH  last good received word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse on good frame.
REQ-010 SHALL have port parity_error  output  1  parity mismatch on current/last frame.
REQ-011 SHALL have port stop_error  output  1  stop bit sampled low.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchronizer (flops reset to 1); all logic below uses the synchronized value rxs.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; edge counter edge_cnt 0..OVERSAMPLE-1; bit counter 0..DWIDTH-1.
REQ-015 IDLE: rxs==0 -> START with edge_cnt=0; par_en/par_typ latched on this transition; later changes ignored until next frame.
REQ-016 Each bit period: edge_cnt increments every cycle and wraps OVERSAMPLE-1 -> 0; decision cycle is edge_cnt==OVERSAMPLE/2+1.
REQ-017 START: decision bit 1 -> IDLE (false start, no outputs change); bit 0 -> DATA at wrap.
REQ-018 DATA: decision bit shifted in LSB-first; after bit DWIDTH-1, at wrap -> PARITY if latched par_en else STOP.
REQ-019 PARITY: at decision, parity_error <= (decision bit != expected); expected = XOR of data for even, XNOR for odd; at wrap -> STOP.
REQ-020 STOP: at decision, stop_error <= (decision bit==0); same cycle -> IDLE (half-bit early exit for resync).
REQ-021 data_valid SHALL pulse exactly one cycle, in the cycle after the STOP decision, only if parity_error==0 and stop_error==0; p_data updates in that same cycle, otherwise holds.
REQ-022 parity_error and stop_error SHALL hold until the next IDLE->START transition, which clears both.
REQ-023 rxs low in IDLE on the same cycle data_valid pulses SHALL start a new frame without loss.
REQ-024 busy SHALL be 1 from the cycle START is entered until the cycle IDLE is re-entered.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, counters 0, shift register 0, p_data 0, data_valid 0, parity_error 0, stop_error 0, busy 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no data_valid; the first frame after release is received normally.

Configuration
REQ-027 With UART_RX_MAJORITY_EN defined: decision bit = majority of rxs sampled at edge_cnt OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-028 Without UART_RX_MAJORITY_EN: decision bit = rxs sampled at edge_cnt OVERSAMPLE/2 only; the decision cycle and latency are identical to REQ-027.

Verification (DWIDTH=8, OVERSAMPLE=16)
REQ-029 par_en=0, send 0xA5, stop=1 -> single data_valid pulse, p_data=0xA5, both errors 0, busy returns to 0.
REQ-030 par_en=1, par_typ=0, send 0x3C with parity bit 0 -> valid, p_data=0x3C; resend with parity bit 1 -> parity_error=1, no data_valid, p_data stays 0x3C.
REQ-031 par_en=1, par_typ=1, send 0x01 with parity bit 0 -> valid; send 0x00 with stop bit 0 -> stop_error=1, no data_valid.
REQ-032 In IDLE, drive rx_in low for 4 cycles -> START entered, then returns to IDLE at decision; no output changes other than busy.
REQ-033 Assert rst during DATA bit 3 of 0x5A -> all outputs 0 immediately; next frame 0xC3 is received with p_data=0xC3.
REQ-034 With UART_RX_MAJORITY_EN, invert rx_in for one clk at edge_cnt=8 of data bit 2 of 0xFF -> p_data=0xFF; without the macro -> p_data=0xFB.
